// File: rtl/vend_pkg.sv
// Shared state codes and parameter defaults for the vending sequencer.
// State codes are fixed because the 7-segment decoder consumes them directly.
package vend_pkg;

  localparam logic [3:0] CodeIdle     = 4'h0;
  localparam logic [3:0] CodeCredit   = 4'h1;
  localparam logic [3:0] CodeReady    = 4'h2;
  localparam logic [3:0] CodeDispense = 4'h3;
  localparam logic [3:0] CodeChange   = 4'h4;
  localparam logic [3:0] CodeError    = 4'hE;

  typedef enum logic [3:0] {
    StIdle     = CodeIdle,
    StCredit   = CodeCredit,
    StReady    = CodeReady,
    StDispense = CodeDispense,
    StChange   = CodeChange,
    StError    = CodeError
  } vend_state_e;

  localparam int unsigned CreditWDefault     = 5;
  localparam int unsigned PriceDefault       = 10;
  localparam int unsigned DebounceCycDefault = 4;
  localparam int unsigned DispenseCycDefault = 8;
  localparam int unsigned TimeoutCycDefault  = 64;

endpackage

// File: rtl/advance_debounce.sv
// Advance button conditioning: 2-FF synchroniser, stability counter and a one-cycle
// pulse on each accepted rising edge. Raw edge to pulse latency is 2 + StableCyc cycles.
module advance_debounce #(
  parameter int unsigned StableCyc = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic advance_i,
  output logic pulse_o
);

  localparam int unsigned CntW = (StableCyc > 1) ? $clog2(StableCyc) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(StableCyc - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic            pulse_q, pulse_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronised level matches the accepted level restarts the count.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    pulse_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = sync2_q;
        pulse_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= advance_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/vend_sequencer.sv
// Vending sale sequencer: coin credit accumulation, sale phases, dispense and idle-timeout
// timing. All outputs are registered; estado_actual feeds the 7-segment decoder.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W     = CreditWDefault,
  parameter int unsigned PRICE        = PriceDefault,
  parameter int unsigned DEBOUNCE_CYC = DebounceCycDefault,
  parameter int unsigned DISPENSE_CYC = DispenseCycDefault,
  parameter int unsigned TIMEOUT_CYC  = TimeoutCycDefault
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_value,
  input  logic                advance,
  input  logic                cancel,
  output logic [3:0]          estado_actual,
  output logic [CREDIT_W-1:0] credit,
  output logic                hay_credito,
  output logic                dispense,
  output logic                change_pulse,
  output logic                coin_reject
);

  localparam int unsigned SumW  = CREDIT_W + 1;
  localparam int unsigned DispW = $clog2(DISPENSE_CYC + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [SumW-1:0]  CreditMax = SumW'((1 << CREDIT_W) - 1);
  localparam logic [SumW-1:0]  PriceW    = SumW'(PRICE);
  localparam logic [DispW-1:0] DispLast  = DispW'(DISPENSE_CYC - 1);
  localparam logic [TmoW-1:0]  TmoLast   = TmoW'(TIMEOUT_CYC - 1);

  vend_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [DispW-1:0]    disp_cnt_q, disp_cnt_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic                reject_q, reject_d;
  logic                dispense_q, change_q, hay_q;

  logic                adv_pulse;
  logic                enough, sale, coin_fits;
  logic [SumW-1:0]     base, sum;

  advance_debounce #(
    .StableCyc (DEBOUNCE_CYC)
  ) u_adv_debounce (
    .clk_i     (clk),
    .rst_i     (rst),
    .advance_i (advance),
    .pulse_o   (adv_pulse)
  );

  // A coin arriving with a sale is added to the balance left after the price is taken.
  assign enough    = ({1'b0, credit_q} >= PriceW);
  assign sale      = (state_q == StReady) && !cancel && adv_pulse && enough;
  assign base      = sale ? ({1'b0, credit_q} - PriceW) : {1'b0, credit_q};
  assign sum       = base + {1'b0, coin_value};
  assign coin_fits = (sum <= CreditMax);

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    disp_cnt_d = '0;
    tmo_d      = '0;
    reject_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (coin_valid) begin
          if (coin_fits) begin
            credit_d = sum[CREDIT_W-1:0];
            state_d  = StCredit;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      StCredit, StReady: begin
        if (cancel) begin
          // The coin in hand is refunded along with the balance.
          state_d  = StChange;
          reject_d = coin_valid;
        end else if (state_q == StReady && adv_pulse && !enough) begin
          state_d  = StError;
          reject_d = coin_valid;
        end else begin
          if (sale) begin
            state_d  = StDispense;
            credit_d = base[CREDIT_W-1:0];
          end
          if (coin_valid) begin
            if (coin_fits) credit_d = sum[CREDIT_W-1:0];
            else           reject_d = 1'b1;
          end
          if (!sale) begin
            if (coin_valid || adv_pulse) tmo_d = '0;
            else if (tmo_q == TmoLast)   state_d = StChange;
            else                         tmo_d = tmo_q + TmoW'(1);
            if (state_q == StCredit && state_d == StCredit && enough) state_d = StReady;
          end
        end
        if (state_d != state_q) tmo_d = '0;
      end
      StDispense: begin
        reject_d = coin_valid;
        if (disp_cnt_q == DispLast) begin
          state_d = (credit_q != '0) ? StChange : StIdle;
        end else begin
          disp_cnt_d = disp_cnt_q + DispW'(1);
        end
      end
      StChange: begin
        reject_d = coin_valid;
        credit_d = '0;
        state_d  = StIdle;
      end
      StError: begin
        reject_d = coin_valid;
      end
      default: begin
        state_d = StError;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      credit_q   <= '0;
      disp_cnt_q <= '0;
      tmo_q      <= '0;
      reject_q   <= 1'b0;
      dispense_q <= 1'b0;
      change_q   <= 1'b0;
      hay_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      disp_cnt_q <= disp_cnt_d;
      tmo_q      <= tmo_d;
      reject_q   <= reject_d;
      dispense_q <= (state_d == StDispense);
      change_q   <= (state_d == StChange);
      hay_q      <= (credit_d != '0);
    end
  end

  assign estado_actual = state_q;
  assign credit        = credit_q;
  assign hay_credito   = hay_q;
  assign dispense      = dispense_q;
  assign change_pulse  = change_q;
  assign coin_reject   = reject_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: expectations are queued as stimulus is driven and
// scored against the registered outputs one cycle later.
module tb_vend_sequencer;

  localparam int unsigned SelSt   = 0;
  localparam int unsigned SelCr   = 1;
  localparam int unsigned SelHay  = 2;
  localparam int unsigned SelDisp = 3;
  localparam int unsigned SelChg  = 4;
  localparam int unsigned SelRej  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [4:0] coin_value = '0;
  logic       advance = 1'b0;
  logic       cancel = 1'b0;
  logic [3:0] estado_actual;
  logic [4:0] credit;
  logic       hay_credito, dispense, change_pulse, coin_reject;

  vend_sequencer #(
    .CREDIT_W     (5),
    .PRICE        (10),
    .DEBOUNCE_CYC (4),
    .DISPENSE_CYC (8),
    .TIMEOUT_CYC  (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .coin_valid    (coin_valid),
    .coin_value    (coin_value),
    .advance       (advance),
    .cancel        (cancel),
    .estado_actual (estado_actual),
    .credit        (credit),
    .hay_credito   (hay_credito),
    .dispense      (dispense),
    .change_pulse  (change_pulse),
    .coin_reject   (coin_reject)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [7:0]  val;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  function automatic logic [7:0] obs(int unsigned sel);
    case (sel)
      SelSt:   obs = {4'h0, estado_actual};
      SelCr:   obs = {3'h0, credit};
      SelHay:  obs = {7'h0, hay_credito};
      SelDisp: obs = {7'h0, dispense};
      SelChg:  obs = {7'h0, change_pulse};
      default: obs = {7'h0, coin_reject};
    endcase
  endfunction

  task automatic exp_o(string tag, int unsigned sel, logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic exp_state(string tag, logic [3:0] st, logic [4:0] cr);
    exp_o({tag, ".state"}, SelSt, {4'h0, st});
    exp_o({tag, ".credit"}, SelCr, {3'h0, cr});
    exp_o({tag, ".hay"}, SelHay, {7'h0, (cr != 5'd0)});
  endtask

  // One clock; outputs are scored 1 time unit after the rising edge.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_cmp++;
      assert (obs(e.sel) === e.val) else begin
        n_bad++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs(e.sel), e.val);
      end
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic coin(string tag, logic [4:0] v, logic [3:0] st, logic [4:0] cr, logic rej);
    coin_valid = 1'b1;
    coin_value = v;
    exp_state(tag, st, cr);
    exp_o({tag, ".reject"}, SelRej, {7'h0, rej});
    step();
    coin_valid = 1'b0;
    coin_value = '0;
  endtask

  // Clean press from READY: six cycles with no sale; on return adv_pulse is live.
  task automatic press(string tag, logic [4:0] cr);
    advance = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_state(tag, 4'h2, cr);
      exp_o({tag, ".disp"}, SelDisp, 8'h0);
      step();
    end
  endtask

  initial begin
    // Reset state
    idle(2);
    exp_state("rst", 4'h0, 5'd0);
    exp_o("rst.disp", SelDisp, 8'h0);
    exp_o("rst.chg", SelChg, 8'h0);
    exp_o("rst.rej", SelRej, 8'h0);
    step();
    rst = 1'b0;

    // 1: two coins of 5 reach READY with credit 10
    coin("t1a", 5'd5, 4'h1, 5'd5, 1'b0);
    coin("t1b", 5'd5, 4'h1, 5'd10, 1'b0);
    exp_state("t1c", 4'h2, 5'd10);
    step();

    // 2: credit 12, clean advance, 8 dispense cycles, change then idle
    coin("t2a", 5'd2, 4'h2, 5'd12, 1'b0);
    press("t2p", 5'd12);
    exp_state("t2s", 4'h3, 5'd2);
    exp_o("t2s.disp", SelDisp, 8'h1);
    step();
    advance = 1'b0;
    for (int i = 0; i < 7; i++) begin
      exp_o("t2d.state", SelSt, 8'h3);
      exp_o("t2d.disp", SelDisp, 8'h1);
      step();
    end
    exp_state("t2c", 4'h4, 5'd2);
    exp_o("t2c.chg", SelChg, 8'h1);
    exp_o("t2c.disp", SelDisp, 8'h0);
    step();
    exp_state("t2i", 4'h0, 5'd0);
    exp_o("t2i.chg", SelChg, 8'h0);
    step();

    // 3: bouncing advance in READY never produces a sale; then cancel refunds
    coin("t3a", 5'd5, 4'h1, 5'd5, 1'b0);
    coin("t3b", 5'd5, 4'h1, 5'd10, 1'b0);
    exp_state("t3c", 4'h2, 5'd10);
    step();
    for (int i = 0; i < 20; i++) begin
      advance = ((i % 4) < 2);
      exp_o("t3t.state", SelSt, 8'h2);
      exp_o("t3t.disp", SelDisp, 8'h0);
      step();
    end
    advance = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_state("t3q", 4'h2, 5'd10);
      exp_o("t3q.disp", SelDisp, 8'h0);
      step();
    end
    cancel = 1'b1;
    exp_state("t3x", 4'h4, 5'd10);
    exp_o("t3x.chg", SelChg, 8'h1);
    step();
    cancel = 1'b0;
    exp_state("t3i", 4'h0, 5'd0);
    step();

    // 4: saturation reject, coin with sale, coin rejected during dispense
    coin("t4a", 5'd28, 4'h1, 5'd28, 1'b0);
    coin("t4b", 5'd5, 4'h2, 5'd28, 1'b1);
    exp_o("t4c.rej", SelRej, 8'h0);
    exp_state("t4c", 4'h2, 5'd28);
    step();
    press("t4p", 5'd28);
    exp_o("t4s.disp", SelDisp, 8'h1);
    coin("t4s", 5'd5, 4'h3, 5'd23, 1'b0);
    advance = 1'b0;
    coin("t4d", 5'd3, 4'h3, 5'd23, 1'b1);
    for (int i = 0; i < 6; i++) begin
      exp_o("t4w.disp", SelDisp, 8'h1);
      step();
    end
    exp_state("t4x", 4'h4, 5'd23);
    exp_o("t4x.chg", SelChg, 8'h1);
    step();
    exp_state("t4i", 4'h0, 5'd0);
    step();

    // 5: idle timeout from CREDIT, then cancel beats a simultaneous advance in READY
    coin("t5a", 5'd6, 4'h1, 5'd6, 1'b0);
    for (int i = 0; i < 63; i++) begin
      exp_o("t5w.state", SelSt, 8'h1);
      exp_o("t5w.chg", SelChg, 8'h0);
      step();
    end
    exp_state("t5t", 4'h4, 5'd6);
    exp_o("t5t.chg", SelChg, 8'h1);
    step();
    exp_state("t5i", 4'h0, 5'd0);
    step();
    coin("t5b", 5'd5, 4'h1, 5'd5, 1'b0);
    coin("t5c", 5'd5, 4'h1, 5'd10, 1'b0);
    exp_state("t5r", 4'h2, 5'd10);
    step();
    press("t5p", 5'd10);
    cancel = 1'b1;
    exp_state("t5x", 4'h4, 5'd10);
    exp_o("t5x.chg", SelChg, 8'h1);
    exp_o("t5x.disp", SelDisp, 8'h0);
    step();
    cancel  = 1'b0;
    advance = 1'b0;
    exp_state("t5y", 4'h0, 5'd0);
    exp_o("t5y.disp", SelDisp, 8'h0);
    step();
    idle(8);

    // 6: reset in the third dispense cycle
    coin("t6a", 5'd5, 4'h1, 5'd5, 1'b0);
    coin("t6b", 5'd5, 4'h1, 5'd10, 1'b0);
    coin("t6c", 5'd2, 4'h2, 5'd12, 1'b0);
    press("t6p", 5'd12);
    exp_state("t6s", 4'h3, 5'd2);
    exp_o("t6s.disp", SelDisp, 8'h1);
    step();
    advance = 1'b0;
    exp_o("t6d2.disp", SelDisp, 8'h1);
    step();
    exp_o("t6d3.disp", SelDisp, 8'h1);
    step();
    rst = 1'b1;
    exp_state("t6r", 4'h0, 5'd0);
    exp_o("t6r.disp", SelDisp, 8'h0);
    exp_o("t6r.chg", SelChg, 8'h0);
    step();
    rst = 1'b0;
    exp_state("t6i", 4'h0, 5'd0);
    exp_o("t6i.disp", SelDisp, 8'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
